// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and control outputs between the board buttons, the stopwatch
// controller and the digit counter / 7-segment driver.
interface stopwatch_ctrl_if;
  logic       btn_start;
  logic       btn_lap;
  logic       btn_clear;
  logic       count_en;
  logic       count_clr;
  logic       lap_hold;
  logic       blank;
  logic [1:0] state;

  // master drives the raw buttons and consumes the controls; slave is the controller
  modport master (
    output btn_start, btn_lap, btn_clear,
    input  count_en, count_clr, lap_hold, blank, state
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear,
    output count_en, count_clr, lap_hold, blank, state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button debounce, IDLE/RUN/PAUSE/LAP FSM, centisecond tick and pause blink.
// Raw button edge to state change is DEB_CYCLES+4 clocks; no backpressure, all outputs registered.
module stopwatch_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int DEB_CYCLES = 50000,
  parameter int BLINK_DIV  = 1250000
) (
  input logic             clk,
  input logic             reset,
  stopwatch_ctrl_if.slave sw
);

  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int BW = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  // bit 0 = start, bit 1 = lap, bit 2 = clear
  logic [2:0]    btn_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    press;
  logic [DW-1:0] deb_cnt [3];

  state_t        cur;
  state_t        nxt;
  logic          clr_take;
  logic          running;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          count_en_q;
  logic          count_clr_q;
  logic          lap_hold_q;
  logic          blank_q;

  assign btn_raw = {sw.btn_clear, sw.btn_lap, sw.btn_start};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      press    <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      // stable only follows a mismatch that has lasted DEB_CYCLES clocks
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt      = cur;
    clr_take = 1'b0;
    case (cur)
      IDLE: begin
        if (press[2]) begin
          clr_take = 1'b1;
        end else if (press[0]) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (press[0]) begin
          nxt = PAUSE;
        end else if (press[1]) begin
          nxt = LAP;
        end
      end
      LAP: begin
        if (press[0]) begin
          nxt = PAUSE;
        end else if (press[1]) begin
          nxt = RUN;
        end
      end
      PAUSE: begin
        if (press[2]) begin
          nxt      = IDLE;
          clr_take = 1'b1;
        end else if (press[0]) begin
          nxt = RUN;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // prescaler advances only while staying in RUN/LAP, so the edge into PAUSE keeps the phase
  assign running = ((cur == RUN) || (cur == LAP)) && ((nxt == RUN) || (nxt == LAP));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur         <= IDLE;
      presc       <= '0;
      blink_cnt   <= '0;
      count_en_q  <= 1'b0;
      count_clr_q <= 1'b0;
      lap_hold_q  <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      cur         <= nxt;
      count_clr_q <= clr_take;
      lap_hold_q  <= (nxt == LAP);
      count_en_q  <= running && (presc == PRESC_MAX);

      if (clr_take) begin
        presc <= '0;
      end else if (running) begin
        presc <= (presc == PRESC_MAX) ? '0 : presc + 1'b1;
      end

      if ((cur == PAUSE) && (nxt == PAUSE)) begin
        if (blink_cnt == BLINK_MAX) begin
          blink_cnt <= '0;
          blank_q   <= ~blank_q;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        blank_q   <= 1'b0;
      end
    end
  end

  assign sw.state     = cur;
  assign sw.count_en  = count_en_q;
  assign sw.count_clr = count_clr_q;
  assign sw.lap_hold  = lap_hold_q;
  assign sw.blank     = blank_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=8:
// a per-cycle vector table for the main run, then hand sequences for reset and minimum presses.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_LAP   = 2'b11;
  localparam int         NV      = 136;

  typedef struct packed {
    logic [2:0] btn;   // {clear, lap, start}
    logic [1:0] st;
    logic       en;
    logic       clr;
    logic       lap;
    logic       blk;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] btn;
  int         checks;
  int         errors;
  vec_t       vt [1:NV];
  int         en_edges [20];

  stopwatch_ctrl_if sw();

  assign sw.btn_start = btn[0];
  assign sw.btn_lap   = btn[1];
  assign sw.btn_clear = btn[2];

  stopwatch_ctrl #(
    .TICK_DIV   (4),
    .DEB_CYCLES (3),
    .BLINK_DIV  (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time expired, required completion before 50000");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] outs();
    return {sw.state, sw.count_en, sw.count_clr, sw.lap_hold, sw.blank};
  endfunction

  task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got st=%b en=%b clr=%b lap=%b blk=%b, required st=%b en=%b clr=%b lap=%b blk=%b",
               name, got[5:4], got[3], got[2], got[1], got[0],
               exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic set_btn(input int idx, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) vt[i].btn[idx] = 1'b1;
  endtask

  task automatic set_st(input int lo, input int hi, input logic [1:0] s);
    for (int i = lo; i <= hi; i++) begin
      vt[i].st  = s;
      vt[i].lap = (s == S_LAP);
    end
  endtask

  task automatic set_blk(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) vt[i].blk = 1'b1;
  endtask

  // Pulse one button for len cycles and count edges until the target state appears.
  task automatic press_wait(input int idx, input int len, input logic [1:0] tgt,
                            input int exp_edges, input string name);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 30) begin
      @(negedge clk);
      btn[idx] = (n < len);
      @(posedge clk);
      #1;
      n++;
      if (sw.state == tgt) seen = 1'b1;
    end
    btn = '0;
    checks++;
    if (!seen || n != exp_edges) begin
      errors++;
      $display("FAIL %s: edges=%0d state=%b, required edges=%0d state=%b",
               name, n, sw.state, exp_edges, tgt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    btn    = '0;
    reset  = 1'b1;

    // Expected per-cycle table; entry i is sampled just after posedge i.
    for (int i = 1; i <= NV; i++) vt[i] = '0;
    set_btn(0, 1, 10);    // start held 10 cycles
    set_btn(0, 28, 29);   // 2-cycle glitch, must be ignored
    set_btn(1, 37, 40);   // lap -> LAP
    set_btn(1, 49, 52);   // lap -> RUN
    set_btn(0, 56, 59);   // start -> PAUSE with prescaler at 2
    set_btn(0, 84, 87);   // start -> RUN while blank=1
    set_btn(0, 93, 96);   // start -> PAUSE
    set_btn(0, 101, 104); // start and clear together in PAUSE
    set_btn(2, 101, 104);
    set_btn(0, 110, 113); // start -> RUN
    set_btn(2, 118, 121); // clear in RUN, ignored
    set_btn(1, 129, 132); // lap -> LAP
    set_st(1, 6, S_IDLE);
    set_st(7, 42, S_RUN);
    set_st(43, 54, S_LAP);
    set_st(55, 61, S_RUN);
    set_st(62, 89, S_PAUSE);
    set_st(90, 98, S_RUN);
    set_st(99, 106, S_PAUSE);
    set_st(107, 115, S_IDLE);
    set_st(116, 134, S_RUN);
    set_st(135, 136, S_LAP);
    en_edges = '{11, 15, 19, 23, 27, 31, 35, 39, 43, 47, 51, 55, 59,
                 92, 96, 120, 124, 128, 132, 136};
    foreach (en_edges[k]) vt[en_edges[k]].en = 1'b1;
    set_blk(70, 77);
    set_blk(86, 89);
    vt[107].clr = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check6("reset values", outs(), 6'b00_0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 1; i <= NV; i++) begin
      @(negedge clk);
      btn = vt[i].btn;
      @(posedge clk);
      #1;
      check6($sformatf("vec%0d", i), outs(),
             {vt[i].st, vt[i].en, vt[i].clr, vt[i].lap, vt[i].blk});
    end

    // Asynchronous reset mid-LAP while count_en is high.
    btn = '0;
    #2;
    reset = 1'b1;
    #1;
    check6("async reset mid-lap", outs(), 6'b00_0000);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check6("after reset release", outs(), 6'b00_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check6($sformatf("idle after reset %0d", i), outs(), 6'b00_0000);
    end

    press_wait(0, 4, S_RUN, 7, "fresh start after reset");
    repeat (6) @(posedge clk);
    #1;
    press_wait(0, 3, S_PAUSE, 7, "minimum-length start press");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM for the 4-digit stopwatch datapath.
- Debounces the start/stop, lap and clear buttons and generates the centisecond count-enable pulse from the 5 MHz clock.
- Drives counter clear, display freeze (lap) and the paused-display blink.
- Sits between the board buttons and the digit counter / 7-segment driver, in the slow clock domain.

Parameters:
- TICK_DIV, 50000, clk cycles per count_en pulse (5 MHz -> 100 Hz).
- DEB_CYCLES, 50000, consecutive stable cycles needed to accept a button level change (10 ms).
- BLINK_DIV, 1250000, clk cycles per blank toggle while paused (0.25 s).

Ports:
- clk  in  1  5 MHz system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- btn_start  in  1  raw start/stop button, asynchronous to clk.
- btn_lap  in  1  raw lap button, asynchronous to clk.
- btn_clear  in  1  raw clear button, asynchronous to clk.
- count_en  out  1  one-cycle pulse; the digit counter advances by one centisecond.
- count_clr  out  1  one-cycle pulse; the digit counter goes to 0000.
- lap_hold  out  1  high = display latch frozen; counter keeps running.
- blank  out  1  high = all digits off (blink phase).
- state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

Behaviour:
- Reset values: state=IDLE, count_en=0, count_clr=0, lap_hold=0, blank=0.
- Reset also zeroes the prescaler, blink counter and debounce counters, and sets synchronizers/stable levels to 0.

Button conditioning (per button, identical):
- 2-flop synchronizer.
- Debounce counter increments while synced != stable and resets to 0 when they are equal.
- When the counter reaches DEB_CYCLES-1 and the mismatch persists, stable takes the synced value at that edge.
- Registered press pulse = stable rising edge; release generates no event.
- Raw-edge-to-state-change latency is exactly DEB_CYCLES+4 edges.
- A glitch shorter than DEB_CYCLES cycles produces no event.

FSM (evaluated on press pulses; priority clear > start > lap; lower-priority presses in the same cycle are dropped):
- IDLE: start -> RUN. clear -> IDLE, count_clr pulse. lap ignored.
- RUN: start -> PAUSE. lap -> LAP. clear ignored.
- LAP: lap -> RUN. start -> PAUSE. clear ignored.
- PAUSE: start -> RUN. clear -> IDLE with count_clr pulse and prescaler zeroed. lap ignored.

count_clr:
- Registered; asserted for exactly the one cycle after the transition edge.

lap_hold:
- 1 iff state==LAP, registered with state.
- Leaving LAP (by lap or start) releases it on the same edge.

Prescaler (width $clog2(TICK_DIV)):
- Increments only in RUN or LAP.
- At TICK_DIV-1 it wraps to 0 and count_en pulses high the next cycle.
- Holds its value in PAUSE, so resume keeps the sub-tick phase; zeroed only by reset or clear.
- First count_en after reset + start occurs TICK_DIV cycles after entering RUN.
- count_en is never high in IDLE/PAUSE.

Blink:
- Blink counter runs only in PAUSE.
- At BLINK_DIV-1 it wraps and blank toggles.
- On any transition out of PAUSE, the counter zeroes and blank=0 on the same edge.
- Entering PAUSE starts with blank=0.

Reset mid-operation:
- Asynchronous; all outputs drop to reset values immediately, with no count_clr pulse.

Test Plan (TICK_DIV=4, DEB_CYCLES=3, BLINK_DIV=8):
1. Reset, then press start held 10 cycles -> state=01 after 7 edges; count_en pulses every 4 cycles, first pulse 4 cycles after state=01; 5 pulses in 20 cycles.
2. From RUN, 2-cycle glitch on btn_start -> no state change, count_en cadence unchanged.
3. RUN, press lap -> state=11, lap_hold=1, count_en continues every 4 cycles; press lap again -> state=01, lap_hold=0.
4. RUN, press start at prescaler=2 -> PAUSE, blank toggles every 8 cycles, no count_en; press start -> RUN, blank=0, first count_en 2 cycles after entering RUN.
5. PAUSE, btn_clear and btn_start rise together -> state=00, single count_clr pulse, blank=0, start press discarded; clear pressed in RUN -> ignored.
6. Assert reset mid-LAP, asynchronously between edges -> state=00, lap_hold=0, count_en=0 immediately; after release the FSM needs a fresh start press.
